practice_session_ctrl: RTL
==========================

// Module: practice_session_ctrl
// PURPOSE
//  Session controller for the practice player. Turns a one-cycle mode-toggle request into practice_mode_active.
//  Scores correct/wrong note events and drives timed LED feedback.
//  Ends the session on song completion, user abort or inactivity timeout, then reports the result.
//  Sits between the key/button front end and the practice player; its outputs go to the LEDs and the score display.
// PARAMETERS
//  FEEDBACK_CYCLES   10_000_000     LED feedback pulse length in clk cycles (200 ms @ 50 MHz), >=1
//  TIMEOUT_CYCLES    1_500_000_000  clk cycles in RUN with no note event before auto-exit (30 s), >=2
//  DONE_HOLD_CYCLES  100_000_000    clk cycles spent in DONE before auto-return to IDLE (2 s), >=1
//  SCORE_W           8              width of each score counter
// PORTS
//  clk                  in   1        system clock
//  rst                  in   1        asynchronous reset, active-high
//  mode_toggle_pulse    in   1        one-cycle request: enter practice (IDLE), abort (RUN), leave early (DONE)
//  correct_evt          in   1        one-cycle pulse from practice player: correct note played
//  wrong_evt            in   1        one-cycle pulse from practice player: wrong note played
//  finished_evt         in   1        practice player song-finished flag (level; held until active drops)
//  practice_mode_active out  1        enable to practice player; high only in RUN
//  session_done         out  1        high while in DONE (celebration display/tone)
//  led_correct          out  1        correct-note feedback LED
//  led_wrong            out  1        wrong-note feedback LED
//  correct_count        out  SCORE_W  correct notes in current/last session, saturating
//  wrong_count          out  SCORE_W  wrong notes in current/last session, saturating
//  session_result       out  2        0 none, 1 completed, 2 aborted, 3 timed out
//  state_out            out  2        0 IDLE, 1 RUN, 2 DONE (3 unused)
// BEHAVIOUR
//  - All outputs are registered. On rst: state IDLE, all outputs 0, all timers/counters 0. Reset mid-session behaves the same (no result kept).
//  - IDLE: correct/wrong/finished ignored. On toggle: go to RUN next cycle; clear both counts, session_result and timers.
//  - practice_mode_active = (state==RUN). It rises 1 cycle after the toggle is sampled.
//  - RUN, priority per cycle (highest first):
//    (1) finished_evt=1 -> DONE; result=1.
//    (2) toggle -> IDLE; result=2.
//    (3) timeout counter == TIMEOUT_CYCLES-1 -> IDLE; result=3.
//  - RUN scoring: correct_evt +1 to correct_count; wrong_evt +1 to wrong_count. Counts saturate at 2^SCORE_W-1.
//    Events are counted even in the cycle that exits RUN (player asserts correct_evt with finished_evt).
//  - Timeout counter: 0 on RUN entry and in any cycle with correct_evt|wrong_evt; otherwise +1 per cycle in RUN.
//  - DONE: hold counter 0 on entry. At DONE_HOLD_CYCLES-1 -> IDLE. Toggle in DONE -> IDLE next cycle. result stays 1.
//  - Counts and session_result hold in IDLE until the next session starts (last score stays visible).
//  - Feedback (any state where events are accepted, i.e. RUN):
//    correct_evt -> led_correct=1, led_wrong=0, fb timer loaded with FEEDBACK_CYCLES.
//    wrong_evt   -> led_wrong=1,   led_correct=0, fb timer loaded with FEEDBACK_CYCLES.
//    A new event restarts the timer and replaces the LED type.
//    Both events in the same cycle: wrong wins for LEDs; both counters increment.
//    LED stays high exactly FEEDBACK_CYCLES cycles, starting the cycle after the event, then clears.
//    Feedback already running when leaving RUN completes normally.
//  - finished_evt outside RUN is ignored. The player clears it once active is low; IDLE->RUN always spends >=1 cycle inactive.
//  - All timers are sized $clog2(param+1); no wrap. Counters stop in states where unused.
// TESTING (bench params: FEEDBACK_CYCLES=4, TIMEOUT_CYCLES=20, DONE_HOLD_CYCLES=8, SCORE_W=3)
//  1. Toggle at t0 -> state_out=1 and practice_mode_active=1 at t0+1; counts 0, result 0.
//  2. In RUN, 3 correct + 1 wrong pulses spaced 2 cycles -> correct_count=3, wrong_count=1.
//     led_wrong high 4 cycles after the wrong pulse; led_correct low meanwhile.
//  3. correct_evt+finished_evt same cycle -> DONE next cycle, correct_count+1, result=1, active=0.
//     IDLE after 8 cycles; counts retained.
//  4. RUN with no events for 20 cycles -> IDLE, result=3.
//     An event at cycle 15 instead delays the exit to 20 cycles after that event.
//  5. 9 correct pulses -> correct_count saturates at 7. Toggle+finished same cycle -> completed, not aborted.
//  6. rst asserted mid-RUN with led_correct high -> outputs 0 asynchronously. Next toggle starts a fresh session.

Source files
------------

// File: rtl/practice_session_ctrl_if.sv
// Bundles the front-end requests and the controller's display/feedback outputs.
// The master side is the key/button front end; the slave side is the session controller.
interface practice_session_ctrl_if #(
    parameter int SCORE_W = 8
);
    logic               mode_toggle_pulse;
    logic               correct_evt;
    logic               wrong_evt;
    logic               finished_evt;
    logic               practice_mode_active;
    logic               session_done;
    logic               led_correct;
    logic               led_wrong;
    logic [SCORE_W-1:0] correct_count;
    logic [SCORE_W-1:0] wrong_count;
    logic [1:0]         session_result;
    logic [1:0]         state_out;

    modport master (
        output mode_toggle_pulse, correct_evt, wrong_evt, finished_evt,
        input  practice_mode_active, session_done, led_correct, led_wrong,
        input  correct_count, wrong_count, session_result, state_out
    );

    modport slave (
        input  mode_toggle_pulse, correct_evt, wrong_evt, finished_evt,
        output practice_mode_active, session_done, led_correct, led_wrong,
        output correct_count, wrong_count, session_result, state_out
    );
endinterface

// File: rtl/practice_session_ctrl.sv
// Practice session controller: IDLE/RUN/DONE sequencing, saturating scoring,
// timed LED feedback and session result reporting. Every output comes from a flop.
module practice_session_ctrl #(
    parameter int FEEDBACK_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES   = 1_500_000_000,
    parameter int DONE_HOLD_CYCLES = 100_000_000,
    parameter int SCORE_W          = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    practice_session_ctrl_if.slave  bus
);
    localparam int FB_W = $clog2(FEEDBACK_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DH_W = $clog2(DONE_HOLD_CYCLES + 1);

    localparam logic [FB_W-1:0] FB_LOAD = FB_W'(FEEDBACK_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DH_W-1:0] DH_LAST = DH_W'(DONE_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [TO_W-1:0]      to_cnt;
    logic [DH_W-1:0]      hold_cnt;
    logic [FB_W-1:0]      fb_cnt;
    logic [SCORE_W-1:0]   correct_q;
    logic [SCORE_W-1:0]   wrong_q;
    logic [1:0]           result_q;
    logic                 led_correct_q;
    logic                 led_wrong_q;
    logic                 active_q;
    logic                 done_q;

    logic toggle;
    logic correct;
    logic wrong;
    logic finished;
    logic any_evt;
    logic timed_out;
    logic hold_over;

    assign toggle    = bus.mode_toggle_pulse;
    assign correct   = bus.correct_evt;
    assign wrong     = bus.wrong_evt;
    assign finished  = bus.finished_evt;
    assign any_evt   = correct | wrong;
    assign timed_out = (to_cnt == TO_LAST);
    assign hold_over = (hold_cnt == DH_LAST);

    // Exit priority in RUN: song completion beats user abort beats inactivity timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (toggle) state_nxt = RUN;
            RUN: begin
                if (finished)       state_nxt = DONE;
                else if (toggle)    state_nxt = IDLE;
                else if (timed_out) state_nxt = IDLE;
            end
            DONE: if (toggle || hold_over) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            active_q <= (state_nxt == RUN);
            done_q   <= (state_nxt == DONE);
        end
    end

    // Scores and result survive into IDLE so the last session stays on the display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            correct_q <= '0;
            wrong_q   <= '0;
            result_q  <= 2'd0;
            to_cnt    <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (toggle) begin
                        correct_q <= '0;
                        wrong_q   <= '0;
                        result_q  <= 2'd0;
                        to_cnt    <= '0;
                    end
                end
                RUN: begin
                    if (correct && (correct_q != '1)) correct_q <= correct_q + 1'b1;
                    if (wrong && (wrong_q != '1))     wrong_q   <= wrong_q + 1'b1;
                    to_cnt <= any_evt ? '0 : to_cnt + 1'b1;
                    if (finished) begin
                        result_q <= 2'd1;
                        hold_cnt <= '0;
                    end else if (toggle) begin
                        result_q <= 2'd2;
                    end else if (timed_out) begin
                        result_q <= 2'd3;
                    end
                end
                DONE: hold_cnt <= hold_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Feedback keeps draining after RUN is left, so a late note still gets its full pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_cnt        <= '0;
            led_correct_q <= 1'b0;
            led_wrong_q   <= 1'b0;
        end else if ((state == RUN) && any_evt) begin
            fb_cnt        <= FB_LOAD;
            led_wrong_q   <= wrong;
            led_correct_q <= ~wrong;
        end else if (fb_cnt != '0) begin
            fb_cnt <= fb_cnt - 1'b1;
            if (fb_cnt == FB_W'(1)) begin
                led_correct_q <= 1'b0;
                led_wrong_q   <= 1'b0;
            end
        end
    end

    assign bus.state_out            = state;
    assign bus.practice_mode_active = active_q;
    assign bus.session_done         = done_q;
    assign bus.led_correct          = led_correct_q;
    assign bus.led_wrong            = led_wrong_q;
    assign bus.correct_count        = correct_q;
    assign bus.wrong_count          = wrong_q;
    assign bus.session_result       = result_q;
endmodule
